// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package data_mem_responder_pkg;

   localparam int unsigned MAX_MEM_LATENCY = 15;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } mem_size_t;

   typedef enum logic [0:0] {
      StIdle,
      StWait
   } ld_state_t;

   // Byte lanes touched by an access of the given size starting at lane.
   function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] lane);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << lane;
         SZ_HALF: m = 4'b0011 << lane;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Illegal size or misaligned half/word.
   function automatic logic align_fault(input mem_size_t size, input logic [1:0] lane);
      logic f;
      case (size)
         SZ_BYTE: f = 1'b0;
         SZ_HALF: f = lane[0];
         SZ_WORD: f = (lane != 2'b00);
         default: f = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core's right-justified view and the word array.
module mem_lane_align
   import data_mem_responder_pkg::*;
(
   input  mem_size_t   st_size_i,
   input  logic [1:0]  st_lane_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_wdata_o,
   output logic        st_fault_o,
   input  mem_size_t   ld_size_i,
   input  logic [1:0]  ld_lane_i,
   input  logic [31:0] ld_word_i,
   output logic [31:0] ld_data_o
);

   logic [31:0] ld_shift;

   // Store side: replicate data across lanes, enable only the addressed lanes.
   always_comb begin
      st_fault_o = align_fault(st_size_i, st_lane_i);
      st_be_o    = st_fault_o ? 4'b0000 : lane_mask(st_size_i, st_lane_i);
      case (st_size_i)
         SZ_BYTE: st_wdata_o = {4{st_data_i[7:0]}};
         SZ_HALF: st_wdata_o = {2{st_data_i[15:0]}};
         default: st_wdata_o = st_data_i;
      endcase
   end

   // Load side: right-justify the addressed lanes and zero-extend.
   always_comb begin
      ld_shift = ld_word_i >> {ld_lane_i, 3'b000};
      case (ld_size_i)
         SZ_BYTE: ld_data_o = {24'h0, ld_shift[7:0]};
         SZ_HALF: ld_data_o = {16'h0, ld_shift[15:0]};
         SZ_WORD: ld_data_o = ld_shift;
         default: ld_data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Retire-side data memory: byte-lane writes, fixed read latency, fault flagging.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read,
   input  logic [31:0] read_address,
   input  logic        write,
   input  logic [31:0] write_address,
   input  logic [31:0] DATA_out,
   input  logic [1:0]  size,
   output logic [31:0] DATA_in,
   output logic        data_valid,
   output logic        busy,
   output logic        err
);

   localparam int unsigned AW       = $clog2(MEM_WORDS);
   localparam logic [31:0] SPAN     = 32'(MEM_WORDS * 4);
   localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);
   // With unit latency the response is formed from the live request, not the latched one.
   localparam bit          DIRECT   = (LATENCY <= 1);

   logic [31:0] mem_q [MEM_WORDS];

   ld_state_t   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [AW-1:0] ld_idx_q, ld_idx_d;
   logic [1:0]  ld_lane_q, ld_lane_d;
   mem_size_t   ld_size_q, ld_size_d;
   logic        ld_fault_q, ld_fault_d;
   logic [31:0] data_in_q, data_in_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic [31:0] st_off, rd_off;
   logic [AW-1:0] st_idx, rd_idx, resp_idx;
   logic [1:0]  st_lane, rd_lane, resp_lane;
   mem_size_t   req_size, resp_size;
   logic        st_align_flt, st_fault, st_accept, st_we;
   logic        rd_fault, rd_accept, resp_fire, resp_fault;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, resp_word, ld_data;

   assign req_size  = mem_size_t'(size);
   assign st_off    = write_address - BASE_ADDR;
   assign rd_off    = read_address - BASE_ADDR;
   assign st_idx    = st_off[AW+1:2];
   assign st_lane   = st_off[1:0];
   assign rd_idx    = rd_off[AW+1:2];
   assign rd_lane   = rd_off[1:0];

   assign busy      = (state_q == StWait);
   assign st_fault  = st_align_flt | (st_off >= SPAN);
   assign st_accept = write & ~busy;
   assign st_we     = st_accept & ~st_fault;
   assign rd_fault  = align_fault(req_size, rd_lane) | (rd_off >= SPAN);
   assign rd_accept = read & ~busy;

   assign resp_idx   = DIRECT ? rd_idx   : ld_idx_q;
   assign resp_lane  = DIRECT ? rd_lane  : ld_lane_q;
   assign resp_size  = DIRECT ? req_size : ld_size_q;
   assign resp_fault = DIRECT ? rd_fault : ld_fault_q;
   assign resp_fire  = DIRECT ? rd_accept : (busy && cnt_q == 4'd1);

   mem_lane_align u_align (
      .st_size_i  (req_size),
      .st_lane_i  (st_lane),
      .st_data_i  (DATA_out),
      .st_be_o    (st_be),
      .st_wdata_o (st_wdata),
      .st_fault_o (st_align_flt),
      .ld_size_i  (resp_size),
      .ld_lane_i  (resp_lane),
      .ld_word_i  (resp_word),
      .ld_data_o  (ld_data)
   );

   // Write-first: a store at the same edge overrides the bytes it touches.
   always_comb begin
      resp_word = mem_q[resp_idx];
      for (int b = 0; b < 4; b++) begin
         if (st_we && st_idx == resp_idx && st_be[b]) begin
            resp_word[8*b +: 8] = st_wdata[8*b +: 8];
         end
      end
   end

   // Byte-lane RAM write; contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (st_we) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem_q[st_idx][8*b +: 8] <= st_wdata[8*b +: 8];
         end
      end
   end

   // Load FSM next state, latency countdown and response formation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ld_idx_d   = ld_idx_q;
      ld_lane_d  = ld_lane_q;
      ld_size_d  = ld_size_q;
      ld_fault_d = ld_fault_q;
      data_in_d  = data_in_q;
      valid_d    = 1'b0;
      err_d      = st_accept & st_fault;
      case (state_q)
         StIdle: begin
            if (rd_accept) begin
               ld_idx_d   = rd_idx;
               ld_lane_d  = rd_lane;
               ld_size_d  = req_size;
               ld_fault_d = rd_fault;
               if (!DIRECT) begin
                  state_d = StWait;
                  cnt_d   = LAT_INIT;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (resp_fire) begin
         valid_d   = 1'b1;
         data_in_d = resp_fault ? 32'h0 : ld_data;
         if (resp_fault) err_d = 1'b1;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         ld_idx_q   <= '0;
         ld_lane_q  <= 2'b00;
         ld_size_q  <= SZ_BYTE;
         ld_fault_q <= 1'b0;
         data_in_q  <= 32'h0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ld_idx_q   <= ld_idx_d;
         ld_lane_q  <= ld_lane_d;
         ld_size_q  <= ld_size_d;
         ld_fault_q <= ld_fault_d;
         data_in_q  <= data_in_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign DATA_in    = data_in_q;
   assign data_valid = valid_q;
   assign err        = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one unit-latency instance and one four-cycle-latency instance.
module tb_data_mem_responder;

   localparam int unsigned MW   = 64;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        rst1, rd1, wr1, dv1, bz1, er1;
   logic [31:0] ra1, wa1, wd1, di1;
   logic [1:0]  sz1;
   logic        rst4, rd4, wr4, dv4, bz4, er4;
   logic [31:0] ra4, wa4, wd4, di4;
   logic [1:0]  sz4;

   data_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(1)) u_d1 (
      .clk(clk), .reset(rst1), .read(rd1), .read_address(ra1), .write(wr1),
      .write_address(wa1), .DATA_out(wd1), .size(sz1), .DATA_in(di1),
      .data_valid(dv1), .busy(bz1), .err(er1)
   );

   data_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(4)) u_d4 (
      .clk(clk), .reset(rst4), .read(rd4), .read_address(ra4), .write(wr4),
      .write_address(wa4), .DATA_out(wd4), .size(sz4), .DATA_in(di4),
      .data_valid(dv4), .busy(bz4), .err(er4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic wr1_do(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input logic want_err);
      wr1 = 1'b1; wa1 = a; wd1 = d; sz1 = s;
      tick();
      chk("d1_wr_err", {31'h0, er1}, {31'h0, want_err});
      wr1 = 1'b0;
      tick();
      chk("d1_wr_err_clear", {31'h0, er1}, 32'h0);
   endtask

   task automatic rd1_chk(input string tag, input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] want, input logic want_err);
      rd1 = 1'b1; ra1 = a; sz1 = s;
      tick();
      chk({tag, "_valid"}, {31'h0, dv1}, 32'h1);
      chk({tag, "_data"}, di1, want);
      chk({tag, "_err"}, {31'h0, er1}, {31'h0, want_err});
      chk({tag, "_busy"}, {31'h0, bz1}, 32'h0);
      rd1 = 1'b0;
      tick();
      chk({tag, "_valid_drop"}, {31'h0, dv1}, 32'h0);
   endtask

   task automatic wr4_do(input logic [31:0] a, input logic [31:0] d);
      wr4 = 1'b1; wa4 = a; wd4 = d; sz4 = 2'b10;
      tick();
      wr4 = 1'b0;
      tick();
   endtask

   initial begin
      int lat;
      rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; ra1 = '0; wa1 = '0; wd1 = '0; sz1 = 2'b10;
      rst4 = 1'b1; rd4 = 1'b0; wr4 = 1'b0; ra4 = '0; wa4 = '0; wd4 = '0; sz4 = 2'b10;
      tick(); tick();
      rst1 = 1'b0; rst4 = 1'b0;
      tick();
      chk("rst_d1_data", di1, 32'h0);
      chk("rst_d1_valid", {31'h0, dv1}, 32'h0);
      chk("rst_d1_busy", {31'h0, bz1}, 32'h0);
      chk("rst_d1_err", {31'h0, er1}, 32'h0);
      chk("rst_d4_data", di4, 32'h0);
      chk("rst_d4_busy", {31'h0, bz4}, 32'h0);

      // Word write then unit-latency word read.
      wr1_do(BASE + 32'h8, 32'hDEAD_BEEF, 2'b10, 1'b0);
      rd1_chk("word_rd", BASE + 32'h8, 2'b10, 32'hDEAD_BEEF, 1'b0);
      chk("data_hold", di1, 32'hDEAD_BEEF);

      // Byte lanes of word 4, then sub-word reads.
      for (int i = 0; i < 4; i++) begin
         wr1_do(BASE + 32'h10 + 32'(i), 32'h11 * 32'(i + 1), 2'b00, 1'b0);
      end
      rd1_chk("half_rd_l2", BASE + 32'h12, 2'b01, 32'h0000_4433, 1'b0);
      rd1_chk("byte_rd_l3", BASE + 32'h13, 2'b00, 32'h0000_0044, 1'b0);
      rd1_chk("word_rd_w4", BASE + 32'h10, 2'b10, 32'h4433_2211, 1'b0);

      // Faulted accesses.
      wr1_do(BASE, 32'h1234_5678, 2'b10, 1'b0);
      wr1_do(BASE + 32'h2, 32'hCAFE_F00D, 2'b10, 1'b1);
      rd1_chk("misalign_unchanged", BASE, 2'b10, 32'h1234_5678, 1'b0);
      rd1_chk("range_hi", BASE + 32'(MW * 4), 2'b10, 32'h0, 1'b1);
      rd1_chk("range_lo", BASE - 32'h4, 2'b10, 32'h0, 1'b1);
      rd1_chk("size_ill", BASE + 32'h8, 2'b11, 32'h0, 1'b1);
      rd1_chk("half_odd", BASE + 32'h11, 2'b01, 32'h0, 1'b1);

      // Simultaneous store and load to one word returns the new data.
      wr1_do(BASE + 32'h14, 32'h0, 2'b10, 1'b0);
      rd1 = 1'b1; ra1 = BASE + 32'h14; wr1 = 1'b1; wa1 = BASE + 32'h14;
      wd1 = 32'hA5A5_A5A5; sz1 = 2'b10;
      tick();
      chk("wfirst_valid", {31'h0, dv1}, 32'h1);
      chk("wfirst_data", di1, 32'hA5A5_A5A5);
      rd1 = 1'b0; wr1 = 1'b0;
      tick();
      rd1_chk("wfirst_persist", BASE + 32'h14, 2'b10, 32'hA5A5_A5A5, 1'b0);

      // Latency 4: read held high across busy, address changes while busy are dropped.
      wr4_do(BASE + 32'h20, 32'h0BAD_F00D);
      wr4_do(BASE + 32'h24, 32'h600D_CAFE);
      wr4_do(BASE + 32'h28, 32'hFFFF_0000);
      rd4 = 1'b1; ra4 = BASE + 32'h20; sz4 = 2'b10;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("l4_busy_k%0d", k), {31'h0, bz4}, {31'h0, (k < 8) && (k % 4 != 0)});
         chk($sformatf("l4_valid_k%0d", k), {31'h0, dv4}, {31'h0, (k == 4) || (k == 8)});
         chk($sformatf("l4_err_k%0d", k), {31'h0, er4}, 32'h0);
         if (k == 4) chk("l4_data_a", di4, 32'h0BAD_F00D);
         if (k == 5) chk("l4_data_a_after_store", di4, 32'h0BAD_F00D);
         if (k == 8) chk("l4_data_c", di4, 32'h600D_CAFE);
         if (k == 12) chk("l4_data_hold", di4, 32'h600D_CAFE);
         if (k < 4) begin
            ra4 = BASE + 32'h28;
         end else if (k == 4) begin
            ra4 = BASE + 32'h24;
            wr4 = 1'b1; wa4 = BASE + 32'h20; wd4 = 32'h1111_2222;
         end else begin
            rd4 = 1'b0; wr4 = 1'b0;
         end
      end

      // Reset during the second busy cycle aborts the load.
      rd4 = 1'b1; ra4 = BASE + 32'h24;
      tick();
      chk("abort_busy1", {31'h0, bz4}, 32'h1);
      rd4 = 1'b0;
      tick();
      chk("abort_busy2", {31'h0, bz4}, 32'h1);
      rst4 = 1'b1;
      tick();
      chk("abort_valid", {31'h0, dv4}, 32'h0);
      chk("abort_busy", {31'h0, bz4}, 32'h0);
      chk("abort_data", di4, 32'h0);
      rst4 = 1'b0;
      tick();
      chk("abort_valid_late", {31'h0, dv4}, 32'h0);
      chk("abort_data_late", di4, 32'h0);

      // Recovery read sees the store made in the earlier data_valid cycle.
      lat = 0;
      rd4 = 1'b1; ra4 = BASE + 32'h20;
      for (int n = 1; n <= 8; n++) begin
         tick();
         rd4 = 1'b0;
         if (dv4 && lat == 0) lat = n;
      end
      chk("recover_latency", 32'(lat), 32'd4);
      chk("recover_data", di4, 32'h1111_2222);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
